// File: rtl/box_drawer_if.sv
// box_drawer_if
//   Location-processor to box-drawer handshake.
//   Handshake rule: a transfer happens on a rising clock edge where m_valid and
//   m_ready are both 1. box_x, box_y and in_color only matter on that edge.
//   m_ready is driven by the drawer and does not depend on m_valid.
//   Signals:
//     m_valid   processor -> drawer  a new box is offered
//     m_ready   drawer -> processor  drawer is idle and will accept
//     box_x     processor -> drawer  new box left column (9 bits)
//     box_y     processor -> drawer  new box top row (9 bits)
//     in_color  processor -> drawer  new box colour (3 bits)
interface box_drawer_if;
  logic       m_valid;
  logic       m_ready;
  logic [8:0] box_x;
  logic [8:0] box_y;
  logic [2:0] in_color;

  modport master (output m_valid, output box_x, output box_y, output in_color,
                  input m_ready);
  modport slave  (input m_valid, input box_x, input box_y, input in_color,
                  output m_ready);
endinterface

// File: rtl/box_drawer.sv
// box_drawer
//   Screen-drawer end of the location handshake. Each accepted box first erases
//   the previously drawn box in BG_COLOR, then rasterises the new box, one pixel
//   per clock, row-major, onto the VGA adapter plot interface. Pixels falling
//   outside the screen still take a cycle but are not plotted.
//   Ports:
//     clock      system clock, rising edge
//     reset_n    asynchronous active-low reset
//     loc        handshake interface (slave side)
//     vga_x      pixel column
//     vga_y      pixel row (low 8 bits of the 9-bit row)
//     vga_color  pixel colour
//     plot       write strobe, one pixel per cycle when 1
//     state_dbg  current FSM state (0 idle, 1 erase, 2 draw)
module box_drawer #(
  parameter logic [8:0] BOX_WIDTH     = 9'd10,
  parameter logic [8:0] BOX_HEIGHT    = 9'd48,
  parameter logic [8:0] SCREEN_WIDTH  = 9'd320,
  parameter logic [8:0] SCREEN_HEIGHT = 9'd240,
  parameter logic [2:0] BG_COLOR      = 3'b000
) (
  input  logic         clock,
  input  logic         reset_n,
  box_drawer_if.slave  loc,
  output logic [8:0]   vga_x,
  output logic [7:0]   vga_y,
  output logic [2:0]   vga_color,
  output logic         plot,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic       have_prev;
  logic [5:0] px, py;
  logic [8:0] new_x, new_y, old_x, old_y;
  logic [2:0] new_color;

  logic       busy, accept;
  logic       last_col, last_row, last_pix;
  logic [8:0] base_x, base_y;
  logic [9:0] sum_x, sum_y;
  logic       on_screen;

  assign busy        = (state != S_IDLE);
  assign loc.m_ready = (state == S_IDLE);
  assign accept      = loc.m_valid && (state == S_IDLE);
  assign state_dbg   = state;

  assign last_col = ({3'd0, px} == (BOX_WIDTH  - 9'd1));
  assign last_row = ({3'd0, py} == (BOX_HEIGHT - 9'd1));
  assign last_pix = last_col && last_row;

  // Sums are one bit wider than the coordinates so a box hanging off the
  // right/bottom edge is clipped rather than wrapped back onto the screen.
  assign base_x    = (state == S_ERASE) ? old_x : new_x;
  assign base_y    = (state == S_ERASE) ? old_y : new_y;
  assign sum_x     = {1'b0, base_x} + {4'd0, px};
  assign sum_y     = {1'b0, base_y} + {4'd0, py};
  assign on_screen = (sum_x < {1'b0, SCREEN_WIDTH}) && (sum_y < {1'b0, SCREEN_HEIGHT});

  // Pixel outputs come straight from state and counters.
  always_comb begin
    plot      = 1'b0;
    vga_x     = 9'd0;
    vga_y     = 8'd0;
    vga_color = 3'd0;
    if (busy) begin
      plot  = on_screen;
      vga_x = sum_x[8:0];
      vga_y = sum_y[7:0];
      vga_color = (state == S_ERASE) ? BG_COLOR : new_color;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)   state_nxt = have_prev ? S_ERASE : S_DRAW;
      S_ERASE: if (last_pix) state_nxt = S_DRAW;
      S_DRAW:  if (last_pix) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      have_prev <= 1'b0;
      px        <= 6'd0;
      py        <= 6'd0;
      new_x     <= 9'd0;
      new_y     <= 9'd0;
      new_color <= 3'd0;
      old_x     <= 9'd0;
      old_y     <= 9'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        new_x     <= loc.box_x;
        new_y     <= loc.box_y;
        new_color <= loc.in_color;
        px        <= 6'd0;
        py        <= 6'd0;
      end else if (busy) begin
        // Row-major walk; the counters return to 0 after the last pixel so the
        // draw pass (after an erase) starts at the box corner.
        if (last_col) begin
          px <= 6'd0;
          py <= last_row ? 6'd0 : py + 6'd1;
        end else begin
          px <= px + 6'd1;
        end
      end
      if ((state == S_DRAW) && last_pix) begin
        old_x     <= new_x;
        old_y     <= new_y;
        have_prev <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_box_drawer.sv
module tb_box_drawer;

  logic       clock;
  logic       reset_n;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_color;
  logic       plot;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];

  box_drawer_if loc();

  box_drawer #(
    .BOX_WIDTH    (9'd2),
    .BOX_HEIGHT   (9'd2),
    .SCREEN_WIDTH (9'd320),
    .SCREEN_HEIGHT(9'd240),
    .BG_COLOR     (3'b000)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .loc      (loc),
    .vga_x    (vga_x),
    .vga_y    (vga_y),
    .vga_color(vga_color),
    .plot     (plot),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [19:0] pix(input int x, input int y, input int c);
    logic [8:0] xx;
    logic [7:0] yy;
    logic [2:0] cc;
    xx = x[8:0];
    yy = y[7:0];
    cc = c[2:0];
    return {xx, yy, cc};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every plotted pixel must match the head of the expected queue.
  always @(negedge clock) begin
    if (plot === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot actual=(%0d,%0d,%0d) required=no_plot",
                 vga_x, vga_y, vga_color);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_color} !== e) begin
          errors++;
          $display("FAIL plot_pixel actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                   vga_x, vga_y, vga_color, e[19:11], e[10:3], e[2:0]);
        end
      end
    end
  end

  // Expected 2x2 box with screen clipping.
  task automatic push_box(input int x, input int y, input int c);
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < 2; i++)
        if ((x + i) < 320 && (y + j) < 240) exp_q.push_back(pix(x + i, y + j, c));
  endtask

  // driver tasks
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_plot", plot, 0);
    chk("reset_vga_x", vga_x, 0);
    chk("reset_vga_y", vga_y, 0);
    chk("reset_vga_color", vga_color, 0);
    chk("reset_state", state_dbg, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset_m_ready", loc.m_ready, 1);
  endtask

  // Called right after a handshake edge; counts busy cycles until m_ready
  // returns, scrambling the box inputs meanwhile (they must be ignored).
  task automatic wait_idle(input int exp_busy, input string name);
    int busy;
    bit done;
    busy = 0;
    done = 0;
    while (!done) begin
      @(negedge clock);
      if (loc.m_ready) done = 1;
      else begin
        busy++;
        loc.box_x    = 9'($urandom_range(0, 511));
        loc.box_y    = 9'($urandom_range(0, 511));
        loc.in_color = 3'($urandom_range(0, 7));
        if (busy > 100) done = 1;
      end
    end
    chk(name, busy, exp_busy);
  endtask

  // Entered on a negedge with the drawer idle.
  task automatic do_txn(input int bx, input int by, input int col, input int exp_busy,
                        input string name);
    loc.m_valid  = 1'b1;
    loc.box_x    = 9'(bx);
    loc.box_y    = 9'(by);
    loc.in_color = 3'(col);
    chk({name, "_ready"}, loc.m_ready, 1);
    @(posedge clock);
    #1;
    loc.m_valid = 1'b0;
    wait_idle(exp_busy, {name, "_busy"});
  endtask

  typedef struct {
    logic [8:0]  bx;
    logic [8:0]  by;
    logic [2:0]  col;
    int          busy;
    int          n;
    logic [19:0] pl[8];
  } vec_t;

  vec_t vecs[4];

  initial begin
    loc.m_valid  = 1'b0;
    loc.box_x    = 9'd0;
    loc.box_y    = 9'd0;
    loc.in_color = 3'd0;
    reset_n      = 1'b0;

    vecs[0] = '{9'd5, 9'd7, 3'b100, 4, 4,
                '{pix(5,7,4), pix(6,7,4), pix(5,8,4), pix(6,8,4),
                  20'd0, 20'd0, 20'd0, 20'd0}};
    vecs[1] = '{9'd6, 9'd7, 3'b100, 8, 8,
                '{pix(5,7,0), pix(6,7,0), pix(5,8,0), pix(6,8,0),
                  pix(6,7,4), pix(7,7,4), pix(6,8,4), pix(7,8,4)}};
    vecs[2] = '{9'd318, 9'd238, 3'b010, 8, 8,
                '{pix(6,7,0), pix(7,7,0), pix(6,8,0), pix(7,8,0),
                  pix(318,238,2), pix(319,238,2), pix(318,239,2), pix(319,239,2)}};
    vecs[3] = '{9'd319, 9'd239, 3'b011, 8, 5,
                '{pix(318,238,0), pix(319,238,0), pix(318,239,0), pix(319,239,0),
                  pix(319,239,3), 20'd0, 20'd0, 20'd0}};

    do_reset();

    // Table-driven transactions: first draw, erase+draw, edge, clipped corner.
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < vecs[v].n; k++) exp_q.push_back(vecs[v].pl[k]);
      do_txn(vecs[v].bx, vecs[v].by, vecs[v].col, vecs[v].busy, $sformatf("vec%0d", v));
      chk($sformatf("vec%0d_drained", v), exp_q.size(), 0);
    end

    // Bottom-right corner as a first draw: 4 cycles, one visible pixel.
    do_reset();
    exp_q.push_back(pix(319, 239, 6));
    do_txn(319, 239, 6, 4, "corner_first");

    // Idle for 50 cycles with no request.
    for (int c = 0; c < 50; c++) begin
      @(negedge clock);
      chk("idle_ready", loc.m_ready, 1);
      chk("idle_plot", plot, 0);
    end

    // Reset during the second draw pixel of an erase+draw pass.
    exp_q.push_back(pix(319, 239, 0));
    exp_q.push_back(pix(30, 30, 5));
    exp_q.push_back(pix(31, 30, 5));
    loc.m_valid  = 1'b1;
    loc.box_x    = 9'd30;
    loc.box_y    = 9'd30;
    loc.in_color = 3'd5;
    @(posedge clock);
    #1;
    loc.m_valid = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midreset_plot", plot, 0);
    chk("midreset_state", state_dbg, 0);
    chk("midreset_ready", loc.m_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("midreset_drained", exp_q.size(), 0);
    push_box(20, 20, 6);
    do_txn(20, 20, 6, 4, "after_reset_no_erase");

    // m_valid held high: accepted on each first idle cycle with the value
    // present on that cycle.
    push_box(20, 20, 0);
    push_box(40, 50, 1);
    loc.m_valid  = 1'b1;
    loc.box_x    = 9'd40;
    loc.box_y    = 9'd50;
    loc.in_color = 3'd1;
    @(posedge clock);
    #1;
    wait_idle(8, "held_first_busy");
    loc.box_x    = 9'd60;
    loc.box_y    = 9'd50;
    loc.in_color = 3'd7;
    push_box(40, 50, 0);
    push_box(60, 50, 7);
    @(posedge clock);
    #1;
    chk("held_second_accept", loc.m_ready, 0);
    loc.m_valid = 1'b0;
    wait_idle(8, "held_second_busy");

    chk("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
